bch_chien_search: RTL and testbench

BCH_CHIEN_SEARCH -- requirements
Module: bch_chien_search

---
 rtl/bch_chien_search.sv | 166 ++++++++++++++++
 tb/tb_bch_chien_search.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bch_chien_search.sv
// Chien search for a binary BCH decoder: evaluates the error locator at every codeword position, highest degree first.
// Optional macro BCH_CHIEN_DECFAIL_EN adds a root counter and the odecfail check.
module bch_chien_search #(
  parameter int m      = 4,
  parameter int k_max  = 5,
  parameter int d      = 7,
  parameter int n      = 15,
  parameter int irrpol = 19,
  parameter int ptr_w  = 4
) (
  input  logic             iclk,
  input  logic             ireset,
  input  logic             iclkena,
  input  logic             iloc_poly_val,
  input  logic [m-1:0]     iloc_poly [0:(d-1)/2],
  input  logic [ptr_w-1:0] iloc_poly_ptr,
  output logic             oval,
  output logic             osop,
  output logic             oeop,
  output logic             oerr,
  output logic [ptr_w-1:0] optr,
  output logic             odecfail
);

  localparam int t     = (d - 1) / 2;
  localparam int q     = (1 << m) - 1;
  localparam int shift = (1 << m) - n;
  localparam int cnt_w = $clog2(((n > k_max) ? n : k_max) + 1);
  localparam int rc_w  = $clog2(t + 2);
  localparam logic [m:0] poly_c = (m + 1)'(irrpol);

  typedef enum logic {WAIT, SEARCH} state_t;

  function automatic logic [m-1:0] mul_alpha(input logic [m-1:0] x);
    logic [m:0] s;
    s = {x, 1'b0};
    if (s[m]) s = s ^ poly_c;
    return s[m-1:0];
  endfunction

  // Constant multiply by alpha^p; unrolls to pure XOR logic for constant p.
  function automatic logic [m-1:0] gf_mul_apow(input logic [m-1:0] x, input int p);
    logic [m-1:0] r;
    int e;
    r = x;
    e = p % q;
    for (int j = 0; j < q; j++)
      if (j < e) r = mul_alpha(r);
    return r;
  endfunction

  state_t             state_q, state_d;
  logic [cnt_w-1:0]   cnt_q, cnt_d;
  logic [ptr_w-1:0]   ptr_q, ptr_d;
  logic [m-1:0]       reg_q [0:t];
  logic [m-1:0]       reg_d [0:t];
  logic               val_q, val_d, sop_q, sop_d, eop_q, eop_d, err_q, err_d;
  logic [m-1:0]       sum;
  logic               root, last;
`ifdef BCH_CHIEN_DECFAIL_EN
  logic [rc_w-1:0]    deg_q, deg_d, rcnt_q, rcnt_d, rcnt_nxt, deg_new;
  logic               decfail_q, decfail_d;
`endif

  // NOTE: every always_comb output gets a default before the case, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    reg_d   = reg_q;
    val_d   = 1'b0;
    sop_d   = 1'b0;
    eop_d   = 1'b0;
    err_d   = 1'b0;
    sum     = '0;
    for (int i = 0; i <= t; i++) sum = sum ^ reg_q[i];
    root = (sum == '0);
    last = (cnt_q == cnt_w'(n - 1));
`ifdef BCH_CHIEN_DECFAIL_EN
    deg_d     = deg_q;
    rcnt_d    = rcnt_q;
    decfail_d = 1'b0;
    deg_new   = '0;
    for (int i = 1; i <= t; i++)
      if (iloc_poly[i] != '0) deg_new = rc_w'(i);
    rcnt_nxt = (root && rcnt_q != rc_w'(t + 1)) ? rcnt_q + rc_w'(1) : rcnt_q;
`endif
    case (state_q)
      WAIT: begin
        if (iloc_poly_val) begin
          state_d = SEARCH;
          cnt_d   = '0;
          ptr_d   = iloc_poly_ptr;
          // Pre-rotate so the first evaluation point is alpha^-(n-1) for shortened codes.
          for (int i = 0; i <= t; i++) reg_d[i] = gf_mul_apow(iloc_poly[i], i * shift);
`ifdef BCH_CHIEN_DECFAIL_EN
          deg_d  = deg_new;
          rcnt_d = '0;
`endif
        end
      end
      SEARCH: begin
        val_d = 1'b1;
        sop_d = (cnt_q == '0);
        eop_d = last;
        err_d = root;
        cnt_d = cnt_q + cnt_w'(1);
        for (int i = 0; i <= t; i++) reg_d[i] = gf_mul_apow(reg_q[i], i);
`ifdef BCH_CHIEN_DECFAIL_EN
        rcnt_d    = rcnt_nxt;
        decfail_d = last && (rcnt_nxt != deg_q);
`endif
        if (last) state_d = WAIT;
      end
      default: state_d = WAIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      state_q <= WAIT;
      val_q   <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef BCH_CHIEN_DECFAIL_EN
      decfail_q <= 1'b0;
`endif
    end else if (iclkena) begin
      state_q <= state_d;
      val_q   <= val_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      err_q   <= err_d;
`ifdef BCH_CHIEN_DECFAIL_EN
      decfail_q <= decfail_d;
`endif
    end
  end

  // NOTE: datapath registers carry no reset; they are always reloaded on acceptance before use.
  always_ff @(posedge iclk) begin
    if (iclkena) begin
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
      reg_q <= reg_d;
`ifdef BCH_CHIEN_DECFAIL_EN
      deg_q  <= deg_d;
      rcnt_q <= rcnt_d;
`endif
    end
  end

  assign oval = val_q;
  assign osop = sop_q;
  assign oeop = eop_q;
  assign oerr = err_q;
  assign optr = ptr_q;
`ifdef BCH_CHIEN_DECFAIL_EN
  assign odecfail = decfail_q;
`else
  assign odecfail = 1'b0;
`endif

endmodule

// File: tb/tb_bch_chien_search.sv
// Bench for bch_chien_search: spec vectors, random codewords against a polynomial-evaluation model,
// back-to-back, mid-search reset and clock-enable/ignored-strobe sequences.
module tb_bch_chien_search;

  localparam int M = 4, D = 7, T = 3, N = 15, NS = 10, PW = 4, Q = 15, IRR = 19;
`ifdef BCH_CHIEN_DECFAIL_EN
  localparam bit DF_ON = 1'b1;
`else
  localparam bit DF_ON = 1'b0;
`endif

  typedef logic [M-1:0] coef_t;
  typedef coef_t poly_t [0:T];
  typedef struct {
    poly_t        poly;
    logic [PW-1:0] ptr;
    bit           short_cw;
    logic [14:0]  mask;
    bit           df;
  } vec_t;
  typedef struct packed {
    logic val, sop, eop, err, df;
    logic [PW-1:0] ptr;
  } obs_t;

  logic iclk = 1'b0;
  logic ireset, iclkena, val15, val10;
  poly_t poly;
  logic [PW-1:0] ptr;
  logic oval15, osop15, oeop15, oerr15, odf15, oval10, osop10, oeop10, oerr10, odf10;
  logic [PW-1:0] optr15, optr10;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 iclk = ~iclk;

  bch_chien_search #(.m(M), .k_max(5), .d(D), .n(N), .irrpol(IRR), .ptr_w(PW)) dut (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .iloc_poly_val(val15),
    .iloc_poly(poly), .iloc_poly_ptr(ptr), .oval(oval15), .osop(osop15),
    .oeop(oeop15), .oerr(oerr15), .optr(optr15), .odecfail(odf15));

  bch_chien_search #(.m(M), .k_max(5), .d(D), .n(NS), .irrpol(IRR), .ptr_w(PW)) dut_short (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .iloc_poly_val(val10),
    .iloc_poly(poly), .iloc_poly_ptr(ptr), .oval(oval10), .osop(osop10),
    .oeop(oeop10), .oerr(oerr10), .optr(optr10), .odecfail(odf10));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic obs_t observe(input bit short_cw);
    obs_t o;
    if (short_cw) o = '{oval10, osop10, oeop10, oerr10, odf10, optr10};
    else          o = '{oval15, osop15, oeop15, oerr15, odf15, optr15};
    return o;
  endfunction

  // Reference field arithmetic: carry-less product reduced by the primitive polynomial.
  function automatic int gf_mul(input int a, input int b);
    int r = 0;
    for (int i = 0; i < M; i++) if ((b >> i) & 1) r ^= a << i;
    for (int i = 2 * M - 2; i >= M; i--) if ((r >> i) & 1) r ^= IRR << (i - M);
    return r;
  endfunction

  function automatic int alpha_pow(input int e);
    int r = 1;
    for (int i = 0; i < (e % Q); i++) r = gf_mul(r, 2);
    return r;
  endfunction

  // Output k covers degree nlen-1-k; it is a root when Lambda(alpha^-degree) == 0.
  task automatic model_cw(input poly_t p, input int nlen, output logic [14:0] mask, output bit df);
    int deg = 0, roots = 0, x, acc, xp;
    mask = '0;
    for (int i = 1; i <= T; i++) if (p[i] != 0) deg = i;
    for (int k = 0; k < nlen; k++) begin
      x = alpha_pow(Q - (nlen - 1 - k));
      acc = 0;
      xp = 1;
      for (int i = 0; i <= T; i++) begin
        acc ^= gf_mul(int'(p[i]), xp);
        xp = gf_mul(xp, x);
      end
      if (acc == 0) begin
        mask[k] = 1'b1;
        roots++;
      end
    end
    df = DF_ON && (roots != deg);
  endtask

  // Called at a negedge; drives the strobe and checks every output of the codeword.
  // Returns at the negedge showing the last output, i.e. in the cycle a new strobe is accepted.
  task automatic run_cw(input vec_t v, input string tag);
    int nlen = v.short_cw ? NS : N;
    obs_t o;
    poly = v.poly;
    ptr  = v.ptr;
    if (v.short_cw) val10 = 1'b1; else val15 = 1'b1;
    @(negedge iclk);
    val15 = 1'b0;
    val10 = 1'b0;
    ptr   = ~v.ptr;
    for (int i = 0; i <= T; i++) poly[i] = coef_t'($urandom_range(0, 15));
    o = observe(v.short_cw);
    check({tag, " oval right after accept"}, 32'(o.val), 0);
    for (int k = 0; k < nlen; k++) begin
      @(negedge iclk);
      o = observe(v.short_cw);
      check($sformatf("%s k=%0d oval", tag, k), 32'(o.val), 1);
      check($sformatf("%s k=%0d oerr", tag, k), 32'(o.err), 32'(v.mask[k]));
      check($sformatf("%s k=%0d osop", tag, k), 32'(o.sop), 32'(k == 0));
      check($sformatf("%s k=%0d oeop", tag, k), 32'(o.eop), 32'(k == nlen - 1));
      check($sformatf("%s k=%0d optr", tag, k), 32'(o.ptr), 32'(v.ptr));
      check($sformatf("%s k=%0d odecfail", tag, k), 32'(o.df), (k == nlen - 1) ? 32'(v.df) : 0);
    end
  endtask

  function automatic vec_t mk(input int c0, c1, c2, c3, input int p, input bit s,
                              input int mask, input bit df);
    vec_t v;
    v.poly = '{coef_t'(c0), coef_t'(c1), coef_t'(c2), coef_t'(c3)};
    v.ptr = PW'(p);
    v.short_cw = s;
    v.mask = 15'(mask);
    v.df = df;
    return v;
  endfunction

  initial begin
    vec_t tbl [5];
    vec_t v;
    obs_t o, held;
    int cnt;

    // alpha^5 = 6, alpha^12 = 15; (1+x)(1+alpha^14 x) = 1 + 8x + 9x^2.
    tbl[0] = mk(1, 0, 0, 0, 3, 1'b0, 0, 1'b0);
    tbl[1] = mk(1, 6, 0, 0, 7, 1'b0, 1 << 9, 1'b0);
    tbl[2] = mk(1, 8, 9, 0, 12, 1'b0, 'h4001, 1'b0);
    tbl[3] = mk(1, 15, 0, 0, 1, 1'b1, 0, DF_ON);
    tbl[4] = mk(0, 0, 0, 0, 0, 1'b0, 'h7fff, DF_ON);

    ireset = 1'b1;
    iclkena = 1'b1;
    val15 = 1'b0;
    val10 = 1'b0;
    ptr = '0;
    poly = '{default: '0};
    repeat (2) @(negedge iclk);
    for (int s = 0; s < 2; s++) begin
      o = observe(s[0]);
      check($sformatf("reset outputs dut%0d", s), 32'({o.val, o.sop, o.eop, o.err, o.df}), 0);
    end
    ireset = 1'b0;
    @(negedge iclk);

    foreach (tbl[i]) begin
      run_cw(tbl[i], $sformatf("vec%0d", i));
      @(negedge iclk);
      check($sformatf("vec%0d oval after eop", i), 32'(oval15 | oval10), 0);
    end

    // Random codewords, alternately back-to-back and with idle gaps.
    for (int r = 0; r < 24; r++) begin
      for (int i = 0; i <= T; i++) v.poly[i] = coef_t'($urandom_range(0, 15));
      v.ptr = PW'($urandom_range(0, 15));
      v.short_cw = ($urandom_range(0, 3) == 0);
      model_cw(v.poly, v.short_cw ? NS : N, v.mask, v.df);
      run_cw(v, $sformatf("rnd%0d", r));
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge iclk);
    end
    repeat (3) @(negedge iclk);

    // Reset after five outputs aborts the codeword.
    poly = tbl[1].poly;
    ptr = 4'd6;
    val15 = 1'b1;
    @(negedge iclk);
    val15 = 1'b0;
    repeat (5) @(negedge iclk);
    check("pre-reset oval", 32'(oval15), 1);
    ireset = 1'b1;
    #1;
    check("oval during reset", 32'({oval15, osop15, oeop15, oerr15, odf15}), 0);
    @(negedge iclk);
    ireset = 1'b0;
    cnt = 0;
    repeat (20) begin
      @(negedge iclk);
      if (oval15) cnt++;
    end
    check("oval count after aborted search", 32'(cnt), 0);
    run_cw(tbl[1], "post-reset");
    repeat (2) @(negedge iclk);

    // Clock enable stall mid-search plus a strobe that must be ignored.
    v = tbl[1];
    v.ptr = 4'd5;
    poly = v.poly;
    ptr = v.ptr;
    val15 = 1'b1;
    @(negedge iclk);
    val15 = 1'b0;
    for (int k = 0; k < N; k++) begin
      @(negedge iclk);
      o = observe(1'b0);
      check($sformatf("stall k=%0d oval", k), 32'(o.val), 1);
      check($sformatf("stall k=%0d oerr", k), 32'(o.err), 32'(v.mask[k]));
      check($sformatf("stall k=%0d optr", k), 32'(o.ptr), 5);
      if (k == 2) begin
        poly = tbl[2].poly;
        ptr = 4'd9;
        val15 = 1'b1;
      end
      if (k == 3) val15 = 1'b0;
      if (k == 4) begin
        held = o;
        iclkena = 1'b0;
        repeat (3) begin
          @(negedge iclk);
          check("outputs held while disabled", 32'(observe(1'b0)), 32'(held));
        end
        iclkena = 1'b1;
      end
    end
    cnt = 0;
    repeat (20) begin
      @(negedge iclk);
      if (oval15) cnt++;
    end
    check("no codeword from ignored strobe", 32'(cnt), 0);
    check("optr unchanged after ignored strobe", 32'(optr15), 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
